tri_span_walker: RTL and testbench
==================================

Name: tri_span_walker

Overview:
- Sequencer that rasterises one 32x32 screen tile for the current triangle.
- Drives the x_ps/y_ps inputs of the combinational inside-triangle edge tester one row at a time.
- Captures the returned 32-bit coverage mask and serialises the covered pixels as an (x,y) fragment stream, one per handshake.
- Sits between the tile/triangle setup stage and the per-pixel interpolation/texturing pipeline.

Parameters:
- TILE_H, 32, number of rows walked per tile (1..32); the row counter is 5 bits, so values above 32 are not supported.
- SKIP_EMPTY, 1, when 1 a row whose mask is zero costs only the setup/capture cycles; when 0 it also spends one idle EMIT cycle.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches tile_x/tile_y and begins a tile walk (ignored while busy)
- abort  in  1  synchronous; returns to IDLE next cycle, no done pulse
- tile_x  in  6  tile column index (pixel x = tile_x*32 + bit)
- tile_y  in  6  tile row index (pixel y = tile_y*32 + row)
- x_ps  out  11  to edge tester; {tile_x_q,5'd0}
- y_ps  out  11  to edge tester; tile_y_q*32 + row
- in_tri  in  32  coverage mask from edge tester; bit i = pixel x_ps+i
- busy  out  1  high from the cycle after start until DONE exits
- done  out  1  one-cycle pulse when the tile walk completes
- pix_valid  out  1  fragment valid
- pix_ready  in  1  downstream accept
- pix_x  out  11  fragment x
- pix_y  out  11  fragment y
- pix_count  out  11  fragments accepted in the current or last tile (saturates at 1024)

Behaviour:
- Reset values: state IDLE; busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0, x_ps=0, y_ps=0, pix_count=0; mask and row registers 0.
- States: IDLE, ROW_SET, ROW_CAP, EMIT, DONE.
- IDLE: on start, latch tile_x/tile_y, set row=0, clear pix_count, go to ROW_SET.
- ROW_SET: x_ps/y_ps are registered and stable this cycle; the edge tester settles. Next state is ROW_CAP.
- ROW_CAP: mask <= in_tri.
  - If in_tri != 0, or SKIP_EMPTY=0, go to EMIT.
  - Otherwise advance the row.
- EMIT:
  - pix_valid = (mask != 0).
  - pix_x = x_ps + index of the lowest set bit of mask; pix_y = y_ps.
  - On pix_valid & pix_ready: clear that bit and increment pix_count.
  - When the bit just cleared was the last set bit (or mask was already 0), advance the row in the same cycle.
  - pix_valid/pix_x/pix_y are held stable while pix_ready=0. No combinational path from pix_ready to pix_valid.
- Row advance: if row == TILE_H-1, go to DONE; else row++, y_ps++, go to ROW_SET.
- DONE: done=1 for exactly one cycle, busy drops the following cycle, then return to IDLE. pix_count holds until the next start.
- Throughput:
  - 1 fragment/cycle with pix_ready tied high.
  - Row overhead is 2 cycles (ROW_SET + ROW_CAP).
  - Empty tile with SKIP_EMPTY=1 takes 2*TILE_H cycles + 1 DONE cycle.
- Emission order: ascending row, then ascending x within the row.
- Abort: takes priority over every other event in the same cycle; pix_valid=0 and busy=0 next cycle. A pending handshake in the abort cycle is not counted.
- Start: start in DONE or while busy is ignored; start in the same cycle as abort in IDLE is ignored.
- Async reset mid-walk forces all outputs to their reset values immediately.
- Width: y_ps = {tile_y_q,5'd0} + row; no overflow is possible for tile indices 0..63 (max 2047).

Test Plan:
- Full coverage: tile_x=2, tile_y=3, in_tri=32'hFFFFFFFF every row, pix_ready=1 -> 1024 fragments in x order 64..95, y 96..127; done at cycle 1024+64+1 after start; pix_count=1024 (saturated).
- Empty tile: in_tri=0, SKIP_EMPTY=1, TILE_H=32 -> no pix_valid; done pulses 65 cycles after start; y_ps steps 0..31 each 2 cycles.
- Sparse mask with backpressure: row 0 only, in_tri=32'h80000011, pix_ready toggling 1-0 -> fragments x=0,4,31 (tile_x=0), each held stable through ready=0 cycles; pix_count=3.
- Abort: abort mid-EMIT after 5 accepted fragments -> next cycle pix_valid=0, busy=0, no done, pix_count=5; a new start then restarts at row 0.
- Start while busy: second start during row 10 -> ignored; walk completes unchanged with a single done.
- Async reset: reset_n low during EMIT -> all outputs 0 immediately; after release, IDLE with busy=0.

Source files
------------

// File: rtl/tri_span_walker.sv
// tri_span_walker: walks one 32x32 tile row by row against the edge tester
// and streams each covered pixel as an (x,y) fragment.
module tri_span_walker #(
  parameter int TILE_H     = 32,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  tile_x,
  input  logic [5:0]  tile_y,
  output logic [10:0] x_ps,
  output logic [10:0] y_ps,
  input  logic [31:0] in_tri,
  output logic        busy,
  output logic        done,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [10:0] pix_count
);

  typedef enum logic [2:0] {
    IDLE,
    ROW_SET,
    ROW_CAP,
    EMIT,
    DONE
  } state_e;

  localparam logic [4:0]  LAST_ROW = 5'(TILE_H - 1);
  localparam logic [10:0] CNT_MAX  = 11'd1024;

  state_e      state_q, state_d;
  logic [5:0]  tx_q, tx_d;
  logic [5:0]  ty_q, ty_d;
  logic [4:0]  row_q, row_d;
  logic [31:0] mask_q, mask_d;
  logic [10:0] cnt_q, cnt_d;

  logic [31:0] mask_rest;
  logic [4:0]  low_idx;
  logic        mask_nz;
  logic        fire;
  logic        row_adv;

  always_comb begin
    low_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask_q[i]) low_idx = 5'(i);
    end
  end

  // Dropping the lowest set bit leaves the rest of the row to emit.
  assign mask_rest = mask_q & (mask_q - 32'd1);
  assign mask_nz   = |mask_q;

  assign x_ps      = {tx_q, 5'd0};
  assign y_ps      = {ty_q, 5'd0} + {6'd0, row_q};
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pix_valid = (state_q == EMIT) && mask_nz;
  assign pix_x     = {tx_q, low_idx};
  assign pix_y     = y_ps;
  assign pix_count = cnt_q;
  assign fire      = pix_valid && pix_ready;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    row_d   = row_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    row_adv = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            tx_d    = tile_x;
            ty_d    = tile_y;
            row_d   = '0;
            cnt_d   = '0;
            state_d = ROW_SET;
          end
        end
        ROW_SET: state_d = ROW_CAP;
        ROW_CAP: begin
          mask_d = in_tri;
          if ((|in_tri) || !SKIP_EMPTY) begin
            state_d = EMIT;
          end else begin
            row_adv = 1'b1;
          end
        end
        EMIT: begin
          if (fire) begin
            mask_d = mask_rest;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 11'd1;
          end
          if (!mask_nz || (fire && (mask_rest == '0))) begin
            row_adv = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (row_adv) begin
        if (row_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 5'd1;
          state_d = ROW_SET;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      row_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tri_span_walker.sv
// tb_tri_span_walker: table-driven and randomized tile walks checked
// against a fragment-queue model of the rasteriser.
module tb_tri_span_walker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  tile_x = '0;
  logic [5:0]  tile_y = '0;
  logic [10:0] x_ps, y_ps, pix_x, pix_y, pix_count;
  logic [31:0] in_tri;
  logic        busy, done, pix_valid;
  logic        pix_ready = 1'b0;

  logic [31:0] row_mask [32];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } frag_t;

  typedef struct {
    int         kind;
    logic [5:0] tx;
    logic [5:0] ty;
    int         rmode;
    int         exp_cnt;
    int         exp_lat;
    int         restart_row;
  } vec_t;

  frag_t exp_q[$];

  always #5 clock = ~clock;

  // Edge tester stand-in: coverage depends only on the row being probed.
  assign in_tri = row_mask[y_ps[4:0]];

  tri_span_walker dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .tile_x(tile_x),
    .tile_y(tile_y),
    .x_ps(x_ps),
    .y_ps(y_ps),
    .in_tri(in_tri),
    .busy(busy),
    .done(done),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_count(pix_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    int p;
    for (int r = 0; r < 32; r++) begin
      case (kind)
        0: row_mask[r] = '1;
        1: row_mask[r] = '0;
        2: row_mask[r] = (r == 0) ? 32'h80000011 : 32'h0;
        3: row_mask[r] = (r == 31) ? 32'h80000000 : 32'h0;
        default: begin
          p = $urandom_range(0, 7);
          if (p < 2) row_mask[r] = '0;
          else if (p == 2) row_mask[r] = '1;
          else row_mask[r] = $urandom & $urandom;
        end
      endcase
    end
  endtask

  // Expected fragments in row-then-x order, and the ready-high walk time.
  task automatic build_model(input logic [5:0] tx, input logic [5:0] ty,
                             output int total, output int lat);
    exp_q.delete();
    total = 0;
    lat = 1;
    for (int r = 0; r < 32; r++) begin
      lat += 2 + $countones(row_mask[r]);
      for (int b = 0; b < 32; b++) begin
        if (row_mask[r][b]) begin
          exp_q.push_back('{x: 11'(int'(tx) * 32 + b),
                            y: 11'(int'(ty) * 32 + r)});
          total++;
        end
      end
    end
  endtask

  task automatic run_tile(input vec_t v, input string tag);
    int total, lat, cyc, exp_cnt;
    bit held, tog, pulsed, rdy;
    frag_t hf, got;
    build_model(v.tx, v.ty, total, lat);
    tile_x = v.tx;
    tile_y = v.ty;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tile_x = 6'($urandom);
    tile_y = 6'($urandom);
    cyc = 1;
    held = 0;
    tog = 1;
    pulsed = 0;
    hf = '0;
    while (!done && cyc < 4000) begin
      if (!busy) chk({tag, "_busy_walk"}, busy, 1);
      if (v.restart_row >= 0 && !pulsed && y_ps[4:0] == 5'(v.restart_row)) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      case (v.rmode)
        0: rdy = 1;
        1: begin rdy = tog; tog = !tog; end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      pix_ready = rdy;
      if (held) begin
        chk({tag, "_hold_valid"}, pix_valid, 1);
        chk({tag, "_hold_xy"}, {pix_x, pix_y}, {hf.x, hf.y});
      end
      held = 0;
      if (pix_valid) begin
        if (rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_extra_frag actual=%0d,%0d required=none",
                     tag, pix_x, pix_y);
          end else begin
            got = exp_q.pop_front();
            if ({pix_x, pix_y} !== {got.x, got.y}) begin
              errors++;
              $display("FAIL %s_frag_xy actual=%0d,%0d required=%0d,%0d",
                       tag, pix_x, pix_y, got.x, got.y);
            end
          end
        end else begin
          held = 1;
          hf.x = pix_x;
          hf.y = pix_y;
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    pix_ready = 1'b0;
    exp_cnt = (v.exp_cnt >= 0) ? v.exp_cnt : ((total > 1024) ? 1024 : total);
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 1);
    if (v.exp_lat >= 0) chk({tag, "_latency"}, cyc, v.exp_lat);
    else if (v.rmode == 0) chk({tag, "_latency_model"}, cyc, lat);
    chk({tag, "_frags_left"}, exp_q.size(), 0);
    chk({tag, "_pix_count"}, pix_count, exp_cnt);
    @(posedge clock); #1;
    chk({tag, "_done_pulse_len"}, done, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_count_hold"}, pix_count, exp_cnt);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_x"}, pix_x, 0);
    chk({tag, "_pix_y"}, pix_y, 0);
    chk({tag, "_x_ps"}, x_ps, 0);
    chk({tag, "_y_ps"}, y_ps, 0);
    chk({tag, "_pix_count"}, pix_count, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int acc, n;

  initial begin
    tbl[0] = '{0, 6'd2, 6'd3, 0, 1024, 1089, -1};
    tbl[1] = '{1, 6'd0, 6'd0, 0, 0, 65, -1};
    tbl[2] = '{2, 6'd0, 6'd0, 1, 3, -1, -1};
    tbl[3] = '{2, 6'd9, 6'd4, 0, 3, 68, -1};
    tbl[4] = '{3, 6'd63, 6'd63, 0, 1, 66, -1};
    tbl[5] = '{0, 6'd1, 6'd1, 0, 1024, 1089, 10};
    fill(1);

    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].kind);
      run_tile(tbl[i], $sformatf("vec%0d", i));
    end

    // start together with abort in IDLE must not launch a walk
    fill(0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", busy, 0);
    @(posedge clock); #1;
    chk("start_abort_idle_busy2", busy, 0);

    // abort after five accepted fragments
    tile_x = 6'd1;
    tile_y = 6'd2;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    pix_ready = 1'b1;
    acc = 0;
    n = 0;
    while (acc < 5 && n < 200) begin
      if (pix_valid) acc++;
      @(posedge clock); #1;
      n++;
    end
    chk("abort_reached_5", acc, 5);
    chk("abort_valid_before", pix_valid, 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    pix_ready = 1'b0;
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pix_count", pix_count, 5);
    @(posedge clock); #1;
    chk("abort_no_done", done, 0);
    rv = '{0, 6'd4, 6'd5, 0, 1024, 1089, -1};
    run_tile(rv, "after_abort");

    // async reset in the middle of EMIT
    fill(0);
    tile_x = 6'd5;
    tile_y = 6'd7;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("areset_in_emit", pix_valid, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    pix_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("areset_release_busy", busy, 0);
    chk("areset_release_valid", pix_valid, 0);

    // randomized walks against the queue model
    for (int i = 0; i < 6; i++) begin
      fill(4);
      rv = '{4, 6'($urandom), 6'($urandom), (i == 0) ? 0 : 2, -1, -1, -1};
      run_tile(rv, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
